// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for the FIFO burst reader: command channel, FIFO read port,
// output stream and status. The engine uses the master view.
interface fifo_burst_reader_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             busy;
  logic             done;

  modport master (
    input  cmd_valid, cmd_len, fifo_empty, fifo_data, m_ready,
    output cmd_ready, fifo_rd_en, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_len, fifo_empty, fifo_data, m_ready,
    input  cmd_ready, fifo_rd_en, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read engine: takes a length command, pops that many words from a
// single-clock FIFO with one cycle of read latency, and streams them out
// through a 3-entry queue that absorbs the latency and downstream stalls.
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input logic                clk,
  input logic                reset,
  fifo_burst_reader_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;
  logic             capture_q;
  logic             capture_last_q;
  logic [WIDTH-1:0] buf_data [0:2];
  logic [2:0]       buf_last;
  logic [1:0]       wr_ptr, rd_ptr, count;
  logic             pop_grant, push, drain;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Pops are only issued when the queue plus the word in flight leave room,
  // so the queue never overflows and m_ready never reaches the FIFO port.
  assign bus.fifo_rd_en = (state == READ) && (remaining != '0) && !bus.fifo_empty &&
                          (({1'b0, count} + {2'b0, capture_q}) < 3'd3);
  assign pop_grant = bus.fifo_rd_en && !bus.fifo_empty;
  assign push      = capture_q;
  assign drain     = bus.m_valid && bus.m_ready;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.m_valid   = (count != 2'd0);
  assign bus.m_data    = buf_data[rd_ptr];
  assign bus.m_last    = bus.m_valid && buf_last[rd_ptr];

  // Burst sequencing and remaining-word count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          if (bus.cmd_len != '0) begin
            state     <= READ;
            remaining <= bus.cmd_len;
          end else begin
            state <= DONE;
          end
        end
        READ: if (pop_grant) begin
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state <= DRAIN;
        end
        DRAIN: if (drain && bus.m_last) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Track the word in flight from the FIFO and whether it closes the burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_q      <= 1'b0;
      capture_last_q <= 1'b0;
    end else begin
      capture_q      <= pop_grant;
      capture_last_q <= pop_grant && (remaining == LEN_W'(1));
    end
  end

  // In-order 3-entry queue; head drives the output stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) buf_data[i] <= '0;
      buf_last <= '0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= bus.fifo_data;
        buf_last[wr_ptr] <= capture_last_q;
        wr_ptr           <= nxt(wr_ptr);
      end
      if (drain) rd_ptr <= nxt(rd_ptr);
      case ({push, drain})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO (registered
// read data) and a stream monitor collecting accepted words.
module tb_fifo_burst_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_burst_reader_if #(.WIDTH(8), .LEN_W(8)) bus ();

  fifo_burst_reader #(.WIDTH(8), .LEN_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // FIFO model
  logic [7:0] mem [0:63];
  int wp = 0, rp = 0, gpops = 0;
  logic clr = 1'b0;
  assign bus.fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (clr) begin
      rp    <= wp;
      gpops <= 0;
    end else if (bus.fifo_rd_en && wp != rp) begin
      bus.fifo_data <= mem[rp[5:0]];
      rp            <= rp + 1;
      gpops         <= gpops + 1;
    end
  end

  // Stream monitor
  logic [7:0] got_d[$];
  logic       got_l[$];
  always @(posedge clk) begin
    if (!reset && bus.m_valid && bus.m_ready) begin
      got_d.push_back(bus.m_data);
      got_l.push_back(bus.m_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fifo_clear();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    got_d.delete();
    got_l.delete();
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) mem[6'(wp + i)] = base + 8'(i);
    wp = wp + n;
  endtask

  // Returns #1 after the handshake edge.
  task automatic send_cmd(input logic [7:0] len);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    while (!bus.cmd_ready && t < 100) begin step(1); t++; end
    chk("cmd_ready wait", 32'(bus.cmd_ready), 32'd1);
    step(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (!bus.done && t < budget) begin step(1); t++; end
    chk(tag, 32'(bus.done), 32'd1);
  endtask

  task automatic chk_stream(input string tag, input int n, input logic [7:0] base,
                            input logic [31:0] last_mask);
    logic [31:0] lm = '0;
    chk({tag, " count"}, 32'(got_d.size()), 32'(n));
    if (got_d.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk({tag, " data"}, 32'(got_d[i]), 32'(base + 8'(i)));
        lm[i] = got_l[i];
      end
      chk({tag, " last"}, lm, last_mask);
    end
  endtask

  initial begin
    logic [7:0] v_rd, v_vld, v_lst, v_dn;
    logic [31:0] v_dat;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.m_ready   = 1'b0;
    bus.fifo_data = '0;
    #2;
    // reset state
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst m_last", 32'(bus.m_last), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst m_data", 32'(bus.m_data), 32'd0);
    step(2);
    reset = 1'b0;
    step(1);

    // 1: reset mid-READ with two words buffered and one in flight
    preload(8'hA0, 6);
    send_cmd(8'd6);
    step(3);
    chk("t1 pre-reset m_valid", 32'(bus.m_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("t1 reset m_valid", 32'(bus.m_valid), 32'd0);
    chk("t1 reset rd_en", 32'(bus.fifo_rd_en), 32'd0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("t1 cmd_ready", 32'(bus.cmd_ready), 32'd1);
    got_d.delete();
    got_l.delete();
    bus.m_ready = 1'b1;
    send_cmd(8'd2);
    wait_done("t1 done", 30);
    chk_stream("t1", 2, 8'hA3, 32'b10);
    step(1);
    fifo_clear();

    // 2: cycle-exact latency, len=4, no backpressure
    preload(8'h10, 4);
    send_cmd(8'd4);
    v_dat = '0;
    for (int i = 0; i < 8; i++) begin
      v_rd[i]  = bus.fifo_rd_en;
      v_vld[i] = bus.m_valid;
      v_lst[i] = bus.m_last;
      v_dn[i]  = bus.done;
      if (i >= 2 && i <= 5) v_dat[8*(i-2) +: 8] = bus.m_data;
      if (i < 7) step(1);
    end
    chk("t2 rd_en pattern", 32'(v_rd), 32'h0F);
    chk("t2 m_valid pattern", 32'(v_vld), 32'h3C);
    chk("t2 m_last pattern", 32'(v_lst), 32'h20);
    chk("t2 done pattern", 32'(v_dn), 32'h40);
    chk("t2 data sequence", v_dat, 32'h13121110);
    chk("t2 cmd_ready after done", 32'(bus.cmd_ready), 32'd1);
    chk_stream("t2", 4, 8'h10, 32'b1000);
    fifo_clear();

    // 3: backpressure, len=8
    preload(8'h30, 8);
    bus.m_ready = 1'b0;
    send_cmd(8'd8);
    step(5);
    chk("t3 stalled pops", 32'(gpops), 32'd3);
    chk("t3 stalled m_data", 32'(bus.m_data), 32'h30);
    step(1);
    chk("t3 held m_data", 32'(bus.m_data), 32'h30);
    chk("t3 held pops", 32'(gpops), 32'd3);
    for (int t = 0; t < 80 && !bus.done; t++) begin
      bus.m_ready = ~bus.m_ready;
      step(1);
    end
    chk("t3 done", 32'(bus.done), 32'd1);
    chk_stream("t3", 8, 8'h30, 32'h80);
    bus.m_ready = 1'b1;
    step(1);
    fifo_clear();

    // 4: FIFO runs dry mid-burst
    preload(8'h40, 2);
    send_cmd(8'd4);
    step(8);
    chk("t4 dry words", 32'(got_d.size()), 32'd2);
    chk("t4 dry busy", 32'(bus.busy), 32'd1);
    chk("t4 dry m_valid", 32'(bus.m_valid), 32'd0);
    preload(8'h42, 2);
    wait_done("t4 done", 30);
    chk("t4 granted pops", 32'(gpops), 32'd4);
    chk_stream("t4", 4, 8'h40, 32'b1000);
    step(1);
    fifo_clear();

    // 5a: zero-length command
    preload(8'h55, 2);
    send_cmd(8'd0);
    chk("t5 done", 32'(bus.done), 32'd1);
    chk("t5 rd_en", 32'(bus.fifo_rd_en), 32'd0);
    step(1);
    chk("t5 done low", 32'(bus.done), 32'd0);
    chk("t5 cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step(2);
    chk("t5 no pops", 32'(gpops), 32'd0);
    chk("t5 no words", 32'(got_d.size()), 32'd0);
    fifo_clear();

    // 5b: command held during a burst waits for IDLE
    preload(8'h50, 7);
    bus.m_ready = 1'b0;
    send_cmd(8'd2);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd5;
    step(6);
    chk("t5 held not accepted", 32'(bus.cmd_ready), 32'd0);
    bus.m_ready = 1'b1;
    wait_done("t5 first done", 30);
    step(1);
    chk("t5 idle", 32'(bus.cmd_ready), 32'd1);
    step(1);
    chk("t5 held accepted", 32'(bus.busy), 32'd1);
    bus.cmd_valid = 1'b0;
    wait_done("t5 second done", 40);
    chk_stream("t5", 7, 8'h50, 32'b1000010);
    step(1);
    fifo_clear();

    // 6: back-to-back commands with cmd_valid held
    preload(8'h60, 5);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd3;
    step(1);
    bus.cmd_len = 8'd2;
    wait_done("t6 first done", 30);
    chk("t6 not ready in done", 32'(bus.cmd_ready), 32'd0);
    step(1);
    chk("t6 ready after done", 32'(bus.cmd_ready), 32'd1);
    step(1);
    chk("t6 second accepted", 32'(bus.busy), 32'd1);
    bus.cmd_valid = 1'b0;
    wait_done("t6 second done", 30);
    chk_stream("t6", 5, 8'h60, 32'b10100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
